// File: rtl/msix_mon_pkg.sv
// Shared types and default sizing for the MSI-X vector monitor.
package msix_mon_pkg;

    localparam int MSIX_NUM_VEC    = 16;
    localparam int MSIX_ADDR_W     = 64;
    localparam int MSIX_DATA_W     = 32;
    localparam int MSIX_FIFO_DEPTH = 8;
    localparam int MSIX_CNT_W      = 16;

    typedef logic [$clog2(MSIX_NUM_VEC)-1:0] vec_id_t;

    // One programmed vector. The struct is sized for the default widths.
    typedef struct packed {
        logic [MSIX_ADDR_W-1:0] addr;
        logic [MSIX_DATA_W-1:0] data;
        logic                   en;
    } vec_entry_t;

endpackage

// File: rtl/msix_evt_fifo.sv
// Synchronous event FIFO. The head is read from registered storage and
// pointers, so it has no combinational path from the push side.
module msix_evt_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [W-1:0]             push_data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             head_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic          do_push, do_pop;

    assign do_push = push_i && (count_q != (PW+1)'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage, pointers and occupancy; memory cleared so the head reads 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/msix_vector_monitor.sv
// Snoops host-memory DW writes, matches them against the MSI-X vector
// table and produces vector events, pending bits, hit counts and errors.
module msix_vector_monitor
    import msix_mon_pkg::*;
#(
    parameter int NUM_VEC    = MSIX_NUM_VEC,
    parameter int ADDR_W     = MSIX_ADDR_W,
    parameter int DATA_W     = MSIX_DATA_W,
    parameter int FIFO_DEPTH = MSIX_FIFO_DEPTH,
    parameter int CNT_W      = MSIX_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       cfg_we,
    input  logic [$clog2(NUM_VEC)-1:0] cfg_id,
    input  logic [ADDR_W-1:0]          cfg_addr,
    input  logic [DATA_W-1:0]          cfg_data,
    input  logic                       cfg_en,
    input  logic                       mask_we,
    input  logic [$clog2(NUM_VEC)-1:0] mask_id,
    input  logic                       mask_val,
    input  logic                       clr_valid,
    input  logic [$clog2(NUM_VEC)-1:0] clr_id,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [$clog2(NUM_VEC)-1:0] evt_id,
    output logic [NUM_VEC-1:0]         pending,
    output logic                       err_valid,
    output logic [$clog2(NUM_VEC)-1:0] err_id,
    input  logic [$clog2(NUM_VEC)-1:0] cnt_rd_id,
    output logic [CNT_W-1:0]           cnt_rd_data
);
    localparam int ID_W = $clog2(NUM_VEC);
    localparam int FC_W = $clog2(FIFO_DEPTH) + 1;

    vec_entry_t       tbl_q [NUM_VEC];
    logic [NUM_VEC-1:0] mask_q, pending_q, pending_d;
    logic [CNT_W-1:0] cnt_q [NUM_VEC];
    logic [CNT_W-1:0] cnt_d [NUM_VEC];
    logic             err_valid_q, err_valid_d;
    logic [ID_W-1:0]  err_id_q, err_id_d;
    logic [CNT_W-1:0] cnt_rd_data_q;

    logic [FC_W-1:0]  fifo_count;
    logic             fifo_full;
    logic             accept, match_found, addr_found, hit, snoop_push;
    logic [ID_W-1:0]  match_id, addr_id, rel_id, push_id;
    logic             rel_found, release_push;

    assign fifo_full = (fifo_count == FC_W'(FIFO_DEPTH));
    assign wr_ready  = !rst && !fifo_full;
    assign accept    = wr_valid && wr_ready;

    // Lowest-index match: full address+data match first, else lowest address-only hit for errors.
    always_comb begin
        match_found = 1'b0;
        match_id    = '0;
        addr_found  = 1'b0;
        addr_id     = '0;
        for (int i = NUM_VEC-1; i >= 0; i--) begin
            if (tbl_q[i].en && tbl_q[i].addr == wr_addr) begin
                addr_found = 1'b1;
                addr_id    = ID_W'(i);
                if (tbl_q[i].data == wr_data) begin
                    match_found = 1'b1;
                    match_id    = ID_W'(i);
                end
            end
        end
    end

    // Lowest pending-and-unmasked vector is the release candidate.
    always_comb begin
        rel_found = 1'b0;
        rel_id    = '0;
        for (int i = NUM_VEC-1; i >= 0; i--) begin
            if (pending_q[i] && !mask_q[i]) begin
                rel_found = 1'b1;
                rel_id    = ID_W'(i);
            end
        end
    end

    assign hit          = accept && match_found;
    assign snoop_push   = hit && !mask_q[match_id];
    assign release_push = rel_found && !snoop_push && !fifo_full;
    assign push_id      = snoop_push ? match_id : rel_id;

    // Next state for pending bits, counters and error pulse; a masked hit overrides a clear.
    always_comb begin
        pending_d   = pending_q;
        cnt_d       = cnt_q;
        err_valid_d = accept && !match_found && addr_found;
        err_id_d    = err_valid_d ? addr_id : err_id_q;
        if (release_push) pending_d[rel_id] = 1'b0;
        if (clr_valid)    pending_d[clr_id] = 1'b0;
        if (hit) begin
            if (mask_q[match_id]) pending_d[match_id] = 1'b1;
            if (cnt_q[match_id] != {CNT_W{1'b1}}) cnt_d[match_id] = cnt_q[match_id] + 1'b1;
        end
    end

    // Table, masks, pending, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_VEC; i++) begin
                tbl_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            mask_q        <= '0;
            pending_q     <= '0;
            err_valid_q   <= 1'b0;
            err_id_q      <= '0;
            cnt_rd_data_q <= '0;
        end else begin
            if (cfg_we) tbl_q[cfg_id] <= '{addr: cfg_addr, data: cfg_data, en: cfg_en};
            if (mask_we) mask_q[mask_id] <= mask_val;
            pending_q     <= pending_d;
            cnt_q         <= cnt_d;
            err_valid_q   <= err_valid_d;
            err_id_q      <= err_id_d;
            cnt_rd_data_q <= cnt_d[cnt_rd_id];
        end
    end

    msix_evt_fifo #(
        .W     (ID_W),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (snoop_push || release_push),
        .push_data_i (push_id),
        .pop_i       (evt_valid && evt_ready),
        .head_o      (evt_id),
        .count_o     (fifo_count)
    );

    assign evt_valid   = (fifo_count != '0);
    assign pending     = pending_q;
    assign err_valid   = err_valid_q;
    assign err_id      = err_id_q;
    assign cnt_rd_data = cnt_rd_data_q;

endmodule

// File: tb/tb_msix_vector_monitor.sv
// Directed scenarios plus randomized traffic checked against a queue-based reference model.
module tb_msix_vector_monitor;
    localparam int NV = 16;
    localparam int AW = 64;
    localparam int DW = 32;
    localparam int FD = 8;
    localparam int CW = 16;
    localparam int IW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          cfg_we;
    logic [IW-1:0] cfg_id;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_data;
    logic          cfg_en;
    logic          mask_we;
    logic [IW-1:0] mask_id;
    logic          mask_val;
    logic          clr_valid;
    logic [IW-1:0] clr_id;
    logic          evt_valid;
    logic          evt_ready;
    logic [IW-1:0] evt_id;
    logic [NV-1:0] pending;
    logic          err_valid;
    logic [IW-1:0] err_id;
    logic [IW-1:0] cnt_rd_id;
    logic [CW-1:0] cnt_rd_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    msix_vector_monitor dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .cfg_we(cfg_we), .cfg_id(cfg_id), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_en(cfg_en),
        .mask_we(mask_we), .mask_id(mask_id), .mask_val(mask_val),
        .clr_valid(clr_valid), .clr_id(clr_id),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
        .pending(pending), .err_valid(err_valid), .err_id(err_id),
        .cnt_rd_id(cnt_rd_id), .cnt_rd_data(cnt_rd_data)
    );

    // Reference model: table contents, masks, pending, counters and the event queue.
    logic [AW-1:0] m_addr [NV];
    logic [DW-1:0] m_data [NV];
    bit            m_en   [NV];
    bit            m_mask [NV];
    bit            m_pend [NV];
    int            m_cnt  [NV];
    int            m_q    [$];
    bit            m_err;
    int            m_err_id;
    int            m_rdcnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_addr[i] = '0; m_data[i] = '0; m_en[i] = 0;
            m_mask[i] = 0;  m_pend[i] = 0;  m_cnt[i] = 0;
        end
        m_q.delete();
        m_err = 0; m_err_id = 0; m_rdcnt = 0;
    endtask

    task automatic check_outputs();
        logic [NV-1:0] ep;
        for (int i = 0; i < NV; i++) ep[i] = m_pend[i];
        chk("evt_valid", evt_valid, m_q.size() != 0);
        if (m_q.size() != 0) chk("evt_id", evt_id, m_q[0]);
        chk("pending", pending, ep);
        chk("err_valid", err_valid, m_err);
        if (m_err) chk("err_id", err_id, m_err_id);
        chk("cnt_rd_data", cnt_rd_data, m_rdcnt);
    endtask

    // One clock: check wr_ready, advance model and DUT, check outputs, drop strobes.
    task automatic step();
        bit pop, acc, spush, new_err;
        int hit, ahit, rel;
        #1;
        chk("wr_ready", wr_ready, !rst && m_q.size() < FD);
        if (rst) begin
            model_reset();
        end else begin
            pop  = evt_ready && m_q.size() != 0;
            acc  = wr_valid && m_q.size() < FD;
            hit  = -1;
            ahit = -1;
            if (acc) begin
                for (int i = 0; i < NV; i++) begin
                    if (m_en[i] && m_addr[i] == wr_addr) begin
                        if (ahit < 0) ahit = i;
                        if (hit < 0 && m_data[i] == wr_data) hit = i;
                    end
                end
            end
            spush = (hit >= 0) && !m_mask[hit];
            rel   = -1;
            if (!spush && m_q.size() < FD) begin
                for (int i = 0; i < NV; i++) begin
                    if (rel < 0 && m_pend[i] && !m_mask[i]) rel = i;
                end
            end
            new_err = acc && hit < 0 && ahit >= 0;
            if (pop) void'(m_q.pop_front());
            if (spush) m_q.push_back(hit);
            if (rel >= 0) begin
                m_q.push_back(rel);
                m_pend[rel] = 0;
            end
            if (clr_valid) m_pend[clr_id] = 0;
            if (hit >= 0) begin
                if (m_mask[hit]) m_pend[hit] = 1;
                if (m_cnt[hit] < CMAX) m_cnt[hit]++;
            end
            m_err = new_err;
            if (new_err) m_err_id = ahit;
            if (mask_we) m_mask[mask_id] = mask_val;
            if (cfg_we) begin
                m_addr[cfg_id] = cfg_addr;
                m_data[cfg_id] = cfg_data;
                m_en[cfg_id]   = cfg_en;
            end
            m_rdcnt = m_cnt[cnt_rd_id];
        end
        @(posedge clk);
        #1;
        check_outputs();
        wr_valid  = 0;
        cfg_we    = 0;
        mask_we   = 0;
        clr_valid = 0;
    endtask

    task automatic prog(input int id, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit en);
        cfg_we = 1; cfg_id = IW'(id); cfg_addr = a; cfg_data = d; cfg_en = en;
        step();
    endtask

    task automatic set_mask(input int id, input bit v);
        mask_we = 1; mask_id = IW'(id); mask_val = v;
        step();
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_valid = 1; wr_addr = a; wr_data = d;
        step();
    endtask

    initial begin
        rst = 1; wr_valid = 0; wr_addr = '0; wr_data = '0;
        cfg_we = 0; cfg_id = '0; cfg_addr = '0; cfg_data = '0; cfg_en = 0;
        mask_we = 0; mask_id = '0; mask_val = 0; clr_valid = 0; clr_id = '0;
        evt_ready = 0; cnt_rd_id = 4'd3;
        model_reset();
        @(posedge clk);
        step();
        step();
        chk("rst_evt_id", evt_id, 0);
        chk("rst_wr_ready", wr_ready, 0);
        rst = 0;
        #1;
        chk("post_rst_wr_ready", wr_ready, 1);

        // Unmasked hit on vector 3.
        prog(3, 64'h1000_0040, 32'hDEAD_0003, 1);
        wr(64'h1000_0040, 32'hDEAD_0003);
        chk("hit3_evt_valid", evt_valid, 1);
        chk("hit3_evt_id", evt_id, 3);
        chk("hit3_cnt", cnt_rd_data, 1);
        chk("hit3_pending", pending[3], 0);
        evt_ready = 1; step(); evt_ready = 0;

        // Address hit with wrong data.
        wr(64'h1000_0040, 32'h0);
        chk("err_pulse", err_valid, 1);
        chk("err_id3", err_id, 3);
        step();
        chk("err_one_cycle", err_valid, 0);
        chk("err_cnt_same", cnt_rd_data, 1);
        chk("err_no_evt", evt_valid, 0);

        // Masked hits, unmask release, clear.
        cnt_rd_id = 4'd5;
        prog(5, 64'h1000_0050, 32'hBEEF_0005, 1);
        set_mask(5, 1);
        wr(64'h1000_0050, 32'hBEEF_0005);
        wr(64'h1000_0050, 32'hBEEF_0005);
        chk("mask5_pending", pending[5], 1);
        chk("mask5_cnt", cnt_rd_data, 2);
        chk("mask5_no_evt", evt_valid, 0);
        set_mask(5, 0);
        step();
        chk("rel5_evt_id", evt_id, 5);
        chk("rel5_pending", pending[5], 0);
        evt_ready = 1; step(); evt_ready = 0;
        step();
        chk("rel5_once", evt_valid, 0);
        set_mask(5, 1);
        wr(64'h1000_0050, 32'hBEEF_0005);
        clr_valid = 1; clr_id = 4'd5; step();
        chk("clr5_pending", pending[5], 0);
        set_mask(5, 0);
        step();
        chk("clr5_no_evt", evt_valid, 0);

        // Masked hit racing a clear on the same vector.
        prog(2, 64'h1000_0020, 32'hCAFE_0002, 1);
        set_mask(2, 1);
        clr_valid = 1; clr_id = 4'd2;
        wr(64'h1000_0020, 32'hCAFE_0002);
        chk("race2_pending", pending[2], 1);
        clr_valid = 1; clr_id = 4'd2; step();
        set_mask(2, 0);

        // Backpressure: fill the FIFO, pop one, accept the ninth.
        for (int i = 0; i < FD; i++) wr(64'h1000_0040, 32'hDEAD_0003);
        chk("bp_full_ready", wr_ready, 0);
        evt_ready = 1; step(); evt_ready = 0;
        chk("bp_pop_ready", wr_ready, 1);
        wr(64'h1000_0020, 32'hCAFE_0002);
        chk("bp_ninth_full", wr_ready, 0);
        evt_ready = 1;
        for (int i = 0; i < FD; i++) begin
            chk("bp_order", evt_id, (i == FD-1) ? 2 : 3);
            step();
        end
        chk("bp_drained", evt_valid, 0);
        evt_ready = 0;

        // Reset with events queued.
        for (int i = 0; i < 4; i++) wr(64'h1000_0040, 32'hDEAD_0003);
        chk("pre_rst_evt", evt_valid, 1);
        rst = 1;
        step();
        chk("mid_rst_evt", evt_valid, 0);
        chk("mid_rst_ready", wr_ready, 0);
        rst = 0;
        for (int i = 0; i < NV; i++) begin
            cnt_rd_id = IW'(i);
            step();
            chk("rst_cnt_zero", cnt_rd_data, 0);
        end
        chk("after_rst_ready", wr_ready, 1);

        // Randomized traffic with unique per-vector addresses.
        for (int i = 0; i < NV; i++) prog(i, 64'h2000_0000 + 64'(i * 8), $urandom, 1);
        for (int n = 0; n < 3000; n++) begin
            int v;
            v = $urandom_range(0, NV-1);
            rst       = ($urandom_range(0, 999) < 2);
            wr_valid  = $urandom_range(0, 1);
            wr_addr   = ($urandom_range(0, 9) == 0) ? 64'h3000_0000 : 64'h2000_0000 + 64'(v * 8);
            wr_data   = ($urandom_range(0, 9) < 7) ? m_data[v] : $urandom;
            cfg_we    = ($urandom_range(0, 99) < 3);
            cfg_id    = IW'($urandom_range(0, NV-1));
            cfg_addr  = 64'h2000_0000 + 64'(cfg_id) * 8;
            cfg_data  = $urandom_range(0, 3);
            cfg_en    = ($urandom_range(0, 3) != 0);
            mask_we   = ($urandom_range(0, 9) == 0);
            mask_id   = IW'($urandom_range(0, NV-1));
            mask_val  = $urandom_range(0, 1);
            clr_valid = ($urandom_range(0, 19) == 0);
            clr_id    = IW'($urandom_range(0, NV-1));
            evt_ready = $urandom_range(0, 1);
            cnt_rd_id = IW'($urandom_range(0, NV-1));
            step();
        end
        rst = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got no end expected end");
        $fatal(1);
    end

endmodule
